// File: rtl/fix2flt_seq_if.sv
// Handshake bundle for fix2flt_seq: fixed-point operand in, float32 result out.
// master = upstream/downstream side, slave = converter side.
interface fix2flt_seq_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/fix2flt_seq.sv
// Signed Q-format to float32 converter; normalizes one bit per clock.
// Results are exact because WIDTH <= 24 fits the 24-bit significand.
module fix2flt_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    fix2flt_seq_if.slave  bus,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    localparam logic [8:0] EXP_INIT = 9'(127 + WIDTH - 1 - FRAC);

    state_t           state, state_nxt;
    logic             sign, sign_nxt;
    logic [WIDTH-1:0] mag, mag_nxt;
    logic [8:0]       exp_q, exp_nxt;
    logic [31:0]      data_q, data_nxt;
    logic             valid_q, valid_nxt;

    logic [WIDTH-1:0] abs_in;
    logic [23:0]      mag_ext;
    logic             unused_exp_msb;

    // Most negative input negates to itself, which as unsigned is the correct magnitude.
    assign abs_in         = bus.in_data[WIDTH-1] ? -bus.in_data : bus.in_data;
    assign mag_ext        = 24'(mag) << (24 - WIDTH);
    assign unused_exp_msb = exp_q[8];

    assign bus.in_ready  = (state == IDLE);
    assign busy          = (state != IDLE);
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sign    <= 1'b0;
            mag     <= '0;
            exp_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            sign    <= sign_nxt;
            mag     <= mag_nxt;
            exp_q   <= exp_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sign_nxt  = sign;
        mag_nxt   = mag;
        exp_nxt   = exp_q;
        data_nxt  = data_q;
        valid_nxt = valid_q;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_nxt  = bus.in_data[WIDTH-1];
                    mag_nxt   = abs_in;
                    exp_nxt   = EXP_INIT;
                    state_nxt = NORM;
                end
            end
            NORM: begin
                if (mag == '0) begin
                    data_nxt  = '0;
                    valid_nxt = 1'b1;
                    state_nxt = DONE;
                end else if (!mag[WIDTH-1]) begin
                    mag_nxt = mag << 1;
                    exp_nxt = exp_q - 9'd1;
                end else begin
                    // Leading one is the implicit bit; the rest become the fraction.
                    data_nxt  = {sign, exp_q[7:0], mag_ext[22:0]};
                    valid_nxt = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (valid_q && bus.out_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fix2flt_seq.sv
// Scoreboarded bench for fix2flt_seq (WIDTH=16, FRAC=8): directed cases,
// backpressure, mid-flight reset and randomized traffic against a float model.
module tb_fix2flt_seq;
    localparam int WIDTH = 16;
    localparam int FRAC  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    fix2flt_seq_if #(.WIDTH(WIDTH)) ifc ();

    fix2flt_seq #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          n_xfer = 0;
    bit          rand_ready = 1'b0;
    bit          forced_ready = 1'b1;
    bit          prev_valid = 1'b0;
    bit          hs_pending = 1'b0;
    logic [31:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact value via double precision, repacked into single-precision fields.
    function automatic void ref_model(input logic [15:0] d, output logic [31:0] f, output int lat);
        real         r;
        logic [63:0] b;
        int          a, e, de;
        a = int'($signed(d));
        if (a == 0) begin
            f   = 32'h0;
            lat = 1;
            return;
        end
        r  = $itor(a) / real'(1 << FRAC);
        b  = $realtobits(r);
        de = int'(b[62:52]) - 1023 + 127;
        f  = {b[63], de[7:0], b[51:29]};
        if (a < 0) a = -a;
        e = 0;
        while ((1 << (e + 1)) <= a) e++;
        lat = (WIDTH - 1 - e) + 1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ifc.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
        end
    end

    // Monitor: samples on the falling edge, when all inputs for the next edge are settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            hs_pending = 1'b0;
        end else begin
            chk("busy_vs_ready", {31'b0, busy}, {31'b0, ~ifc.in_ready});
            if (hs_pending) begin
                chk("ready_after_xfer", {31'b0, ifc.in_ready}, 32'd1);
                chk("valid_after_xfer", {31'b0, ifc.out_valid}, 32'd0);
                hs_pending = 1'b0;
            end
            if (ifc.out_valid) begin
                chk("ready_low_in_done", {31'b0, ifc.in_ready}, 32'd0);
                if (!prev_valid) begin
                    held = ifc.out_data;
                    if (sb.size() == 0) begin
                        chk("unexpected_output", ifc.out_data, 32'hxxxxxxxx);
                    end else begin
                        chk("latency", cyc - sb[0].acc, sb[0].lat);
                    end
                end else begin
                    chk("data_stable", ifc.out_data, held);
                end
                if (ifc.out_ready && sb.size() > 0) begin
                    chk("out_data", ifc.out_data, sb[0].data);
                    void'(sb.pop_front());
                    n_xfer++;
                    hs_pending = 1'b1;
                end
            end
            prev_valid = ifc.out_valid && !ifc.out_ready;
        end
    end

    task automatic send(input logic [15:0] d, input logic [31:0] exp_data, input int lat);
        bit   ok;
        exp_t e;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.data = exp_data;
            e.lat  = lat;
            e.acc  = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 16'($urandom);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb.size(), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [31:0] f;
        int          lat, x0, n;

        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
        ifc.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_data", ifc.out_data, 32'h0);
        chk("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, ifc.in_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;

        send(16'h0100, 32'h3F800000, 8);
        send(16'h0180, 32'h3FC00000, 8);
        send(16'hFF00, 32'hBF800000, 8);
        send(16'h8000, 32'hC3000000, 1);
        send(16'h0001, 32'h3B800000, 16);
        send(16'h7FFF, 32'h42FFFE00, 2);
        send(16'h0000, 32'h00000000, 1);
        drain("directed_drain");

        // Backpressure with ignored input pulses while busy.
        forced_ready = 1'b0;
        repeat (2) @(posedge clk);
        send(16'h0100, 32'h3F800000, 8);
        n = 0;
        while (!ifc.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", {31'b0, ifc.out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            ifc.in_valid = (i % 2 == 0);
            ifc.in_data  = 16'($urandom);
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        x0 = n_xfer;
        forced_ready = 1'b1;
        repeat (8) @(posedge clk);
        chk("bp_single_xfer", n_xfer - x0, 32'd1);
        drain("bp_drain");

        // Reset in the middle of a long normalization.
        send(16'h0001, 32'h3B800000, 16);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        chk("midrst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, ifc.in_ready}, 32'd1);
        chk("midrst_out_data", ifc.out_data, 32'h0);
        repeat (20) @(posedge clk);
        send(16'h0100, 32'h3F800000, 8);
        drain("midrst_drain");

        rand_ready = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            d = 16'($urandom >> $urandom_range(16, 31));
            if ($urandom_range(0, 1) == 1) d = -d;
            if ($urandom_range(0, 50) == 0) d = 16'h8000;
            ref_model(d, f, lat);
            send(d, f, lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain("random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
